branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side branch predictor: the front end of branch resolution. Predicts taken/not-taken and the target for the instruction at `if_pc` using a direct-mapped table of 2-bit saturating counters plus a tagged target buffer (BTB). Trains from the execute-stage branch result: the `BR_*` op and the resolved taken flag. Flags mispredictions with the redirect PC, and keeps saturating branch/mispredict statistics counters.

## Interface
- `INDEX_W`, 6: table index width; 2^INDEX_W entries. Tag width is 30-INDEX_W.
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `if_valid`  in  1  fetch lookup valid
- `if_pc`  in  32  fetch PC (word aligned)
- `pred_taken`  out  1  predicted taken
- `pred_target`  out  32  predicted next PC
- `ex_valid`  in  1  execute-stage instruction valid
- `ex_pc`  in  32  PC of the resolving instruction
- `ex_op`  in  3  branch op, `BR_*` encodings from defines.vh
- `ex_taken`  in  1  resolved branch decision
- `ex_target`  in  32  resolved taken target
- `ex_pred_taken`  in  1  prediction carried down the pipe for this instruction
- `ex_pred_target`  in  32  predicted next PC carried down the pipe
- `mispredict`  out  1  flush/redirect request
- `redirect_pc`  out  32  correct next PC when `mispredict`=1
- `br_count`  out  32  resolved branches, saturating
- `mp_count`  out  32  mispredictions, saturating

## Operation
- **Index and tag**
  - idx = pc[INDEX_W+1:2]
  - tag = pc[31:INDEX_W+2]
- **Per entry state**
  - valid bit
  - tag
  - 2-bit counter `ctr`
  - 32-bit target
- **Lookup** (combinational from registered state)
  - hit = `if_valid` & valid[idx] & tag match
  - `pred_taken` = hit & ctr[idx][1]
  - `pred_target` = `pred_taken` ? target[idx] : `if_pc`+4
  - `if_valid`=0 gives `pred_taken`=0 and `pred_target`=`if_pc`+4.
- **Update**
  - An update happens when `ex_valid`=1 and `ex_op`≠`BR_NO`; the entry at idx(`ex_pc`) is written.
  - Entry was a tag hit:
    - `BR_GO` sets ctr=11.
    - Conditional ops (`BR_NE`/`BR_EQ`/`BR_GE`/`BR_LT`) move ctr toward the outcome: increment if `ex_taken`, decrement otherwise, saturating at 00 and 11.
    - Target is written with `ex_target` only if `ex_taken`.
  - Entry was a miss or invalid:
    - Install only if `ex_taken`: valid=1, tag written, target=`ex_target`, ctr=11 for `BR_GO`, 10 otherwise.
    - Not-taken misses leave the entry unchanged.
  - Unknown `ex_op` encodings are treated as `BR_NO`.
- **Mispredict** (combinational)
  - Asserted on an update cycle when `ex_taken`≠`ex_pred_taken`, or when `ex_taken` & `ex_target`≠`ex_pred_target`.
  - `redirect_pc` = `ex_taken` ? `ex_target` : `ex_pc`+4, driven regardless of `mispredict`.
  - Forced 0 when `rst_n`=0.
- **Statistics**
  - `br_count` +1 on every update cycle.
  - `mp_count` +1 when `mispredict`.
  - Both saturate at 0xFFFFFFFF.
- **PC arithmetic**: +4 is a 32-bit wrap; 0xFFFFFFFC+4 = 0x00000000.

## Timing
- Prediction latency 0: same cycle as `if_pc`.
- Update latency 1: a write is visible to a lookup on the next cycle.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update entry (no bypass).
- `mispredict` and `redirect_pc` are valid in the same cycle as the ex inputs. The consumer samples them at the next edge.
- No backpressure: one update per cycle, every cycle accepted.
- **Reset** (`rst_n` sampled low at an edge):
  - all valid=0, ctr=01, targets and tags=0
  - `br_count`=`mp_count`=0
  - `pred_taken`=0 from the following cycle
- A reset asserted mid-update discards that update; counters are not incremented.

## Test plan
- **Cold miss**
  - Stimulus: after reset, `if_pc`=0x100, `if_valid`=1.
  - Required: `pred_taken`=0, `pred_target`=0x104, `br_count`=0.
- **Install and predict**
  - Stimulus: ex update `ex_pc`=0x100, `BR_EQ`, taken, `ex_target`=0x200, `ex_pred_taken`=0.
  - Required: same cycle `mispredict`=1, `redirect_pc`=0x200. Next cycle lookup 0x100 gives `pred_taken`=1, `pred_target`=0x200; `mp_count`=1.
- **Hysteresis**
  - Stimulus: from ctr=10 at 0x100, one not-taken `BR_NE` resolve.
  - Required: `redirect_pc`=0x104, ctr=01, lookup predicts not taken. A second not-taken gives ctr=00; three taken resolves give ctr=11 and no further growth.
- **Aliasing**
  - Stimulus: install 0x100 taken, then lookup 0x100+(4<<INDEX_W)=0x200.
  - Required: tag mismatch, `pred_taken`=0, `pred_target`=0x204.
- **Simultaneous / BR_NO / target change**
  - Stimulus 1: update and lookup same idx in one cycle. Required: old prediction seen.
  - Stimulus 2: `BR_NO` with `ex_valid`=1. Required: no state change, `mispredict`=0, `br_count` unchanged.
  - Stimulus 3: `BR_GO` taken with `ex_target`≠stored target. Required: `mispredict`=1 and the target is replaced.
- **Saturation and reset**
  - Stimulus: force `br_count`=0xFFFFFFFF, then resolve. Required: the count holds.
  - Stimulus: pulse `rst_n`=0 during an update. Required: all tables invalid and counters zero next cycle.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal taken/not-taken predictor (2-bit saturating
// counters) with a direct-mapped tagged target buffer, trained from the
// execute-stage branch result, plus saturating branch/mispredict statistics.

package branch_predictor_pkg;
    typedef enum logic [2:0] {
        BR_NO = 3'd0,
        BR_GO = 3'd1,
        BR_NE = 3'd2,
        BR_EQ = 3'd3,
        BR_GE = 3'd4,
        BR_LT = 3'd5
    } br_op_e;
endpackage

module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [2:0]  ex_op,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = 30 - INDEX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];

    logic [INDEX_W-1:0] if_idx;
    logic [INDEX_W-1:0] ex_idx;
    logic [TAG_W-1:0]   if_tag;
    logic [TAG_W-1:0]   ex_tag;

    logic       if_hit;
    logic       ex_hit;
    logic       is_go;
    logic       is_cond;
    logic       update;
    logic [1:0] ctr_upd;

    // Word-aligned PCs: the two low bits carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[INDEX_W+1:2];
    assign if_tag = if_pc[31:INDEX_W+2];
    assign ex_idx = ex_pc[INDEX_W+1:2];
    assign ex_tag = ex_pc[31:INDEX_W+2];

    // Fetch lookup: zero-latency read of the registered table, no bypass.
    always_comb begin
        if_hit      = if_valid && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = if_hit && ctr_q[if_idx][1];
        pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);
    end

    // Execute-side decode, next counter value and mispredict detection.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        is_go   = 1'b0;
        is_cond = 1'b0;
        case (br_op_e'(ex_op))
            BR_GO:                      is_go   = 1'b1;
            BR_NE, BR_EQ, BR_GE, BR_LT: is_cond = 1'b1;
            default:                    ;
        endcase

        update = ex_valid && (is_go || is_cond);
        ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

        if (is_go) begin
            ctr_upd = 2'b11;
        end else if (ex_taken) begin
            ctr_upd = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : (ctr_q[ex_idx] + 2'd1);
        end else begin
            ctr_upd = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : (ctr_q[ex_idx] - 2'd1);
        end

        mispredict  = rst_n && update &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
        redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
    end

    // Table training and statistics; a reset cycle discards any update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the whole table is reset (not just the valid bits) so that
            // counters restart weakly not-taken and tags/targets are known.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= 2'b01;
                target_q[i] <= '0;
            end
            br_count <= '0;
            mp_count <= '0;
        end else if (update) begin
            // NOTE: non-blocking assignments keep every register update based on
            // the pre-edge state, which is what the no-bypass lookup relies on.
            if (br_count != 32'hFFFF_FFFF) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict && (mp_count != 32'hFFFF_FFFF)) begin
                mp_count <= mp_count + 32'd1;
            end

            if (ex_hit) begin
                ctr_q[ex_idx] <= ctr_upd;
                if (ex_taken) begin
                    target_q[ex_idx] <= ex_target;
                end
            end else if (ex_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                ctr_q[ex_idx]    <= is_go ? 2'b11 : 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench. Each driven cycle pushes the
// expected outputs from a reference table model; the test task pops and
// compares them while the outputs are stable, then checks a few fixed
// values taken directly from the intended behaviour.

module tb_branch_predictor;

    localparam logic [2:0] BR_NO = 3'd0;
    localparam logic [2:0] BR_GO = 3'd1;
    localparam logic [2:0] BR_NE = 3'd2;
    localparam logic [2:0] BR_EQ = 3'd3;
    localparam logic [2:0] BR_BAD = 3'd7;
    localparam int N = 64;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [2:0]  ex_op;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mp_count;

    branch_predictor #(.INDEX_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_count(br_count), .mp_count(mp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rst;
        logic        iv;
        logic [31:0] ipc;
        logic        ev;
        logic [31:0] epc;
        logic [2:0]  op;
        logic        et;
        logic [31:0] etgt;
        logic        ept;
        logic [31:0] eptgt;
    } stim_t;

    typedef struct {
        string        nm;
        logic [129:0] v;
    } exp_t;

    exp_t  sb[$];
    stim_t cur;
    int    n_cmp = 0;
    int    n_fail = 0;

    // Reference model state
    logic        m_valid [N];
    logic [23:0] m_tag   [N];
    logic [1:0]  m_ctr   [N];
    logic [31:0] m_tgt   [N];
    logic [31:0] m_br;
    logic [31:0] m_mp;

    function automatic stim_t mk(string nm, logic iv, logic [31:0] ipc, logic ev,
                                 logic [31:0] epc, logic [2:0] op, logic et,
                                 logic [31:0] etgt, logic ept, logic [31:0] eptgt,
                                 logic rst = 1'b1);
        stim_t s;
        s.nm = nm; s.rst = rst; s.iv = iv; s.ipc = ipc; s.ev = ev; s.epc = epc;
        s.op = op; s.et = et; s.etgt = etgt; s.ept = ept; s.eptgt = eptgt;
        return s;
    endfunction

    function automatic stim_t look(string nm, logic [31:0] ipc);
        return mk(nm, 1'b1, ipc, 1'b0, 32'h0, BR_NO, 1'b0, 32'h0, 1'b0, 32'h0);
    endfunction

    function automatic logic m_upd(stim_t s);
        return s.ev && (s.op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5});
    endfunction

    function automatic logic m_mispredict(stim_t s);
        return s.rst && m_upd(s) && ((s.et != s.ept) || (s.et && (s.etgt != s.eptgt)));
    endfunction

    function automatic logic [129:0] m_expect(stim_t s);
        logic [5:0]  i;
        logic        hit;
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] rpc;
        i    = s.ipc[7:2];
        hit  = s.iv && m_valid[i] && (m_tag[i] == s.ipc[31:8]);
        pt   = hit && m_ctr[i][1];
        ptgt = pt ? m_tgt[i] : s.ipc + 32'd4;
        rpc  = s.et ? s.etgt : s.epc + 32'd4;
        return {pt, ptgt, m_mispredict(s), rpc, m_br, m_mp};
    endfunction

    task automatic model_update(stim_t s);
        logic [5:0] j;
        j = s.epc[7:2];
        if (!s.rst) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 1'b0; m_tag[k] = '0; m_ctr[k] = 2'b01; m_tgt[k] = '0;
            end
            m_br = '0;
            m_mp = '0;
        end else if (m_upd(s)) begin
            if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
            if (m_mispredict(s) && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
            if (m_valid[j] && m_tag[j] == s.epc[31:8]) begin
                if (s.op == BR_GO)    m_ctr[j] = 2'b11;
                else if (s.et)        m_ctr[j] = (m_ctr[j] == 2'b11) ? 2'b11 : m_ctr[j] + 2'd1;
                else                  m_ctr[j] = (m_ctr[j] == 2'b00) ? 2'b00 : m_ctr[j] - 2'd1;
                if (s.et) m_tgt[j] = s.etgt;
            end else if (s.et) begin
                m_valid[j] = 1'b1;
                m_tag[j]   = s.epc[31:8];
                m_tgt[j]   = s.etgt;
                m_ctr[j]   = (s.op == BR_GO) ? 2'b11 : 2'b10;
            end
        end
    endtask

    task automatic drive(stim_t s);
        rst_n = s.rst; if_valid = s.iv; if_pc = s.ipc; ex_valid = s.ev; ex_pc = s.epc;
        ex_op = s.op; ex_taken = s.et; ex_target = s.etgt;
        ex_pred_taken = s.ept; ex_pred_target = s.eptgt;
    endtask

    // Close the current cycle in the model, drive the next one, push its expectation.
    task automatic step(stim_t s);
        exp_t e;
        @(posedge clk);
        model_update(cur);
        @(negedge clk);
        cur = s;
        drive(s);
        e.nm = s.nm;
        e.v  = m_expect(s);
        sb.push_back(e);
        #2;
    endtask

    function automatic logic [129:0] observed();
        return {pred_taken, pred_target, mispredict, redirect_pc, br_count, mp_count};
    endfunction

    task automatic test_reset();
        stim_t q[$];
        exp_t  e;
        q.push_back(mk("reset", 1'b0, 32'h0, 1'b0, 32'h0, BR_NO, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        q.push_back(look("cold_miss", 32'h100));
        foreach (q[k]) begin
            step(q[k]);
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h expected %h", e.nm, observed(), e.v);
            end
        end
        n_cmp++;
        if ({pred_taken, pred_target, br_count} !== {1'b0, 32'h104, 32'h0}) begin
            n_fail++;
            $display("FAIL cold_fixed: observed %b %h %h expected 0 00000104 00000000",
                     pred_taken, pred_target, br_count);
        end
    endtask

    task automatic test_install();
        exp_t e;
        step(mk("install", 1'b1, 32'h100, 1'b1, 32'h100, BR_EQ, 1'b1, 32'h200, 1'b0, 32'h104));
        e = sb.pop_front();
        n_cmp++;
        if (observed() !== e.v) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", e.nm, observed(), e.v);
        end
        n_cmp++;
        if ({mispredict, redirect_pc} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL install_fixed: observed %b %h expected 1 00000200", mispredict, redirect_pc);
        end
        step(look("install_predict", 32'h100));
        e = sb.pop_front();
        n_cmp++;
        if (observed() !== e.v) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", e.nm, observed(), e.v);
        end
        n_cmp++;
        if ({pred_taken, pred_target, mp_count} !== {1'b1, 32'h200, 32'h1}) begin
            n_fail++;
            $display("FAIL predict_fixed: observed %b %h %h expected 1 00000200 00000001",
                     pred_taken, pred_target, mp_count);
        end
    endtask

    task automatic test_hysteresis();
        stim_t q[$];
        exp_t  e;
        q.push_back(mk("hyst_nt1", 1'b1, 32'h100, 1'b1, 32'h100, BR_NE, 1'b0, 32'h0, 1'b1, 32'h200));
        q.push_back(look("hyst_look1", 32'h100));
        q.push_back(mk("hyst_nt2", 1'b1, 32'h100, 1'b1, 32'h100, BR_NE, 1'b0, 32'h0, 1'b0, 32'h104));
        for (int t = 0; t < 4; t++)
            q.push_back(mk($sformatf("hyst_t%0d", t), 1'b1, 32'h100, 1'b1, 32'h100, BR_NE, 1'b1,
                           32'h200, 1'b0, 32'h104));
        q.push_back(mk("hyst_nt3", 1'b1, 32'h100, 1'b1, 32'h100, BR_NE, 1'b0, 32'h0, 1'b1, 32'h200));
        q.push_back(look("hyst_look2", 32'h100));
        foreach (q[k]) begin
            step(q[k]);
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h expected %h", e.nm, observed(), e.v);
            end
        end
        // Saturated at 11, one not-taken leaves 10: still predicts taken.
        n_cmp++;
        if ({pred_taken, pred_target} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL hyst_saturate: observed %b %h expected 1 00000200", pred_taken, pred_target);
        end
        step(mk("hyst_nt4", 1'b1, 32'h100, 1'b1, 32'h100, BR_NE, 1'b0, 32'h0, 1'b1, 32'h200));
        e = sb.pop_front();
        n_cmp++;
        if (observed() !== e.v) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", e.nm, observed(), e.v);
        end
        step(look("hyst_look3", 32'h100));
        e = sb.pop_front();
        n_cmp++;
        if ({pred_taken, pred_target} !== {1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL hyst_weak_nt: observed %b %h expected 0 00000104", pred_taken, pred_target);
        end
    endtask

    task automatic test_target_alias();
        stim_t q[$];
        exp_t  e;
        step(mk("go_newtgt", 1'b0, 32'h0, 1'b1, 32'h100, BR_GO, 1'b1, 32'h300, 1'b1, 32'h200));
        e = sb.pop_front();
        n_cmp++;
        if ({mispredict, redirect_pc} !== {1'b1, 32'h300}) begin
            n_fail++;
            $display("FAIL go_target_change: observed %b %h expected 1 00000300", mispredict, redirect_pc);
        end
        q.push_back(look("go_look", 32'h100));
        q.push_back(look("alias_look", 32'h200));
        foreach (q[k]) begin
            step(q[k]);
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h expected %h", e.nm, observed(), e.v);
            end
        end
        n_cmp++;
        if ({pred_taken, pred_target} !== {1'b0, 32'h204}) begin
            n_fail++;
            $display("FAIL alias_fixed: observed %b %h expected 0 00000204", pred_taken, pred_target);
        end
    endtask

    task automatic test_simultaneous();
        stim_t q[$];
        exp_t  e;
        q.push_back(mk("sim_nt1", 1'b1, 32'h100, 1'b1, 32'h100, BR_NE, 1'b0, 32'h0, 1'b1, 32'h300));
        q.push_back(mk("sim_nt2", 1'b1, 32'h100, 1'b1, 32'h100, BR_NE, 1'b0, 32'h0, 1'b1, 32'h300));
        foreach (q[k]) begin
            step(q[k]);
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h expected %h", e.nm, observed(), e.v);
            end
        end
        // Counter moves 10 -> 01 this edge; the same-cycle lookup still sees 10.
        n_cmp++;
        if ({pred_taken, pred_target} !== {1'b1, 32'h300}) begin
            n_fail++;
            $display("FAIL sim_old_pred: observed %b %h expected 1 00000300", pred_taken, pred_target);
        end
        step(look("sim_after", 32'h100));
        e = sb.pop_front();
        n_cmp++;
        if (observed() !== e.v) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", e.nm, observed(), e.v);
        end
    endtask

    task automatic test_no_update();
        stim_t q[$];
        exp_t  e;
        q.push_back(mk("nu_go", 1'b1, 32'h100, 1'b1, 32'h100, BR_GO, 1'b1, 32'h300, 1'b1, 32'h300));
        q.push_back(mk("nu_br_no", 1'b1, 32'h100, 1'b1, 32'h200, BR_NO, 1'b1, 32'h999, 1'b0, 32'h0));
        q.push_back(mk("nu_bad_op", 1'b1, 32'h100, 1'b1, 32'h200, BR_BAD, 1'b1, 32'h998, 1'b0, 32'h0));
        q.push_back(mk("nu_ex_idle", 1'b1, 32'h100, 1'b0, 32'h200, BR_EQ, 1'b1, 32'h997, 1'b0, 32'h0));
        q.push_back(mk("nu_nt_miss", 1'b1, 32'h100, 1'b1, 32'h1000, BR_EQ, 1'b0, 32'h0, 1'b1, 32'h500));
        q.push_back(look("nu_look", 32'h100));
        foreach (q[k]) begin
            step(q[k]);
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h expected %h", e.nm, observed(), e.v);
            end
        end
        n_cmp++;
        if ({pred_taken, pred_target} !== {1'b1, 32'h300}) begin
            n_fail++;
            $display("FAIL nu_entry_kept: observed %b %h expected 1 00000300", pred_taken, pred_target);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        step(mk("wrap", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, BR_EQ, 1'b0, 32'h0, 1'b0, 32'h0));
        e = sb.pop_front();
        n_cmp++;
        if (observed() !== e.v) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", e.nm, observed(), e.v);
        end
        n_cmp++;
        if ({pred_target, redirect_pc, mispredict} !== {32'h0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_fixed: observed %h %h %b expected 00000000 00000000 0",
                     pred_target, redirect_pc, mispredict);
        end
    endtask

    task automatic test_saturation();
        stim_t q[$];
        exp_t  e;
        force dut.br_count = 32'hFFFF_FFFF;
        force dut.mp_count = 32'hFFFF_FFFF;
        #1;
        release dut.br_count;
        release dut.mp_count;
        m_br = 32'hFFFF_FFFF;
        m_mp = 32'hFFFF_FFFF;
        q.push_back(mk("sat_upd1", 1'b0, 32'h0, 1'b1, 32'h40, BR_EQ, 1'b1, 32'h80, 1'b0, 32'h44));
        q.push_back(mk("sat_upd2", 1'b0, 32'h0, 1'b1, 32'h40, BR_EQ, 1'b1, 32'h88, 1'b1, 32'h80));
        q.push_back(look("sat_after", 32'h40));
        foreach (q[k]) begin
            step(q[k]);
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h expected %h", e.nm, observed(), e.v);
            end
        end
        n_cmp++;
        if ({br_count, mp_count} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL sat_fixed: observed %h %h expected ffffffff ffffffff", br_count, mp_count);
        end
    endtask

    task automatic test_reset_mid_update();
        stim_t q[$];
        exp_t  e;
        q.push_back(mk("rst_upd", 1'b1, 32'h100, 1'b1, 32'h140, BR_EQ, 1'b1, 32'h180, 1'b0, 32'h144, 1'b0));
        q.push_back(mk("rst_look1", 1'b1, 32'h100, 1'b0, 32'h0, BR_NO, 1'b0, 32'h0, 1'b0, 32'h0));
        q.push_back(look("rst_look2", 32'h140));
        foreach (q[k]) begin
            step(q[k]);
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e.v) begin
                n_fail++;
                $display("FAIL %s: observed %h expected %h", e.nm, observed(), e.v);
            end
        end
        n_cmp++;
        if ({pred_taken, pred_target, br_count, mp_count} !== {1'b0, 32'h144, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_fixed: observed %b %h %h %h expected 0 00000144 00000000 00000000",
                     pred_taken, pred_target, br_count, mp_count);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 1'b0; m_tag[k] = '0; m_ctr[k] = 2'b01; m_tgt[k] = '0;
        end
        m_br = '0;
        m_mp = '0;
        cur = mk("init", 1'b0, 32'h0, 1'b0, 32'h0, BR_NO, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(cur);

        test_reset();
        test_install();
        test_hysteresis();
        test_target_alias();
        test_simultaneous();
        test_no_update();
        test_wrap();
        test_saturation();
        test_reset_mid_update();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
